// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================
// core_ctrl_pkg : shared types and constants for core pipeline control
// Rev 1.0
// ============================================================
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ============================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================
// hazard_stall_controller : stall/bubble/flush sequencer for the 5-stage core
// Rev 1.0
// ============================================================
module hazard_stall_controller
  import core_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_is_muldiv,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  input  logic             muldiv_done,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_stall,
  output logic             EX_MEM_bubble,
  output logic             MEM_WB_bubble,
  output logic             IF_ID_flush,
  output logic             muldiv_start,
  output logic             md_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int                    c_MD_CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [c_MD_CNT_W-1:0] c_MD_LIMIT = c_MD_CNT_W'(MD_TIMEOUT);
  localparam logic [c_MD_CNT_W-1:0] c_MD_ONE   = c_MD_CNT_W'(1);

  ctrl_state_t           r_state, w_state_next;
  logic [c_MD_CNT_W-1:0] r_md_cnt, w_md_cnt_next;
  logic                  r_md_timeout_err, w_md_timeout_set;
  logic                  w_mem_wait, w_load_use;
  logic                  w_pc_stall, w_if_id_stall, w_id_ex_stall, w_id_ex_bubble;
  logic                  w_ex_mem_stall, w_ex_mem_bubble, w_mem_wb_bubble;
  logic                  w_if_id_flush, w_muldiv_start;

  assign w_mem_wait = EX_MEM_MemAccess && !dmem_ready;
  assign w_load_use = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                      ((ID_EX_rd == ID_rs1 && ID_uses_rs1) ||
                       (ID_EX_rd == ID_rs2 && ID_uses_rs2));

  always_comb begin
    w_state_next     = r_state;
    w_md_cnt_next    = r_md_cnt;
    w_md_timeout_set = 1'b0;
    w_pc_stall       = 1'b0;
    w_if_id_stall    = 1'b0;
    w_id_ex_stall    = 1'b0;
    w_id_ex_bubble   = 1'b0;
    w_ex_mem_stall   = 1'b0;
    w_ex_mem_bubble  = 1'b0;
    w_mem_wb_bubble  = 1'b0;
    w_if_id_flush    = 1'b0;
    w_muldiv_start   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A dmem wait freezes EX too, so a branch or muldiv there waits its turn.
        if (w_mem_wait) begin
          {w_pc_stall, w_if_id_stall, w_id_ex_stall} = 3'b111;
          {w_ex_mem_stall, w_mem_wb_bubble}          = 2'b11;
          w_state_next                               = ST_MEM_WAIT;
        end else if (EX_branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (ID_EX_is_muldiv) begin
          w_muldiv_start                             = 1'b1;
          {w_pc_stall, w_if_id_stall, w_id_ex_stall} = 3'b111;
          w_ex_mem_bubble                            = 1'b1;
          w_md_cnt_next                              = c_MD_ONE;
          w_state_next                               = ST_MD_WAIT;
        end else if (w_load_use) begin
          {w_pc_stall, w_if_id_stall, w_id_ex_bubble} = 3'b111;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          {w_pc_stall, w_if_id_stall, w_id_ex_stall} = 3'b111;
          {w_ex_mem_stall, w_mem_wb_bubble}          = 2'b11;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        // Releasing in the done cycle lets EX_MEM capture the result.
        if (muldiv_done) begin
          w_md_cnt_next = '0;
          w_state_next  = ST_RUN;
        end else if (r_md_cnt == c_MD_LIMIT) begin
          w_md_timeout_set = 1'b1;
          w_md_cnt_next    = '0;
          w_state_next     = ST_RUN;
        end else begin
          {w_pc_stall, w_if_id_stall, w_id_ex_stall} = 3'b111;
          w_ex_mem_bubble                            = 1'b1;
          w_md_cnt_next                              = r_md_cnt + c_MD_ONE;
        end
      end
      default: begin
        w_state_next  = ST_RUN;
        w_md_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_RUN;
      r_md_cnt         <= '0;
      r_md_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_md_cnt <= w_md_cnt_next;
      if (w_md_timeout_set) begin
        r_md_timeout_err <= 1'b1;
      end
    end
  end

  // Controls are gated by rst_n so a reset silences the pipeline at once.
  assign PC_stall       = rst_n && w_pc_stall;
  assign IF_ID_stall    = rst_n && w_if_id_stall;
  assign ID_EX_stall    = rst_n && w_id_ex_stall;
  assign ID_EX_bubble   = rst_n && w_id_ex_bubble;
  assign EX_MEM_stall   = rst_n && w_ex_mem_stall;
  assign EX_MEM_bubble  = rst_n && w_ex_mem_bubble;
  assign MEM_WB_bubble  = rst_n && w_mem_wb_bubble;
  assign IF_ID_flush    = rst_n && w_if_id_flush;
  assign muldiv_start   = rst_n && w_muldiv_start;
  assign md_timeout_err = r_md_timeout_err;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (PC_stall),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_flush),
    .count (flush_events)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================
// tb_hazard_stall_controller : directed self-checking bench for the stall controller
// Rev 1.0
// ============================================================
module tb_hazard_stall_controller;

  localparam int c_MD_TIMEOUT = 8;
  localparam int c_CNT_W      = 4;

  // Control vector bit order:
  // PC_stall IF_ID_stall ID_EX_stall ID_EX_bubble EX_MEM_stall EX_MEM_bubble MEM_WB_bubble IF_ID_flush muldiv_start
  localparam logic [8:0] c_NONE  = 9'b000000000;
  localparam logic [8:0] c_LU    = 9'b110100000;
  localparam logic [8:0] c_FLUSH = 9'b000100010;
  localparam logic [8:0] c_MEMF  = 9'b111010100;
  localparam logic [8:0] c_MDS   = 9'b111001001;
  localparam logic [8:0] c_MDW   = 9'b111001000;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
  logic ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_is_muldiv;
  logic EX_branch_taken, EX_MEM_MemAccess, dmem_ready, muldiv_done;
  logic PC_stall, IF_ID_stall, ID_EX_stall, ID_EX_bubble, EX_MEM_stall;
  logic EX_MEM_bubble, MEM_WB_bubble, IF_ID_flush, muldiv_start, md_timeout_err;
  logic [c_CNT_W-1:0] stall_cycles, flush_events;
  logic [8:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ctl = {PC_stall, IF_ID_stall, ID_EX_stall, ID_EX_bubble, EX_MEM_stall,
                EX_MEM_bubble, MEM_WB_bubble, IF_ID_flush, muldiv_start};

  hazard_stall_controller #(.MD_TIMEOUT(c_MD_TIMEOUT), .CNT_W(c_CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_rs1           (ID_rs1),
    .ID_rs2           (ID_rs2),
    .ID_uses_rs1      (ID_uses_rs1),
    .ID_uses_rs2      (ID_uses_rs2),
    .ID_EX_rd         (ID_EX_rd),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_is_muldiv  (ID_EX_is_muldiv),
    .EX_branch_taken  (EX_branch_taken),
    .EX_MEM_MemAccess (EX_MEM_MemAccess),
    .dmem_ready       (dmem_ready),
    .muldiv_done      (muldiv_done),
    .PC_stall         (PC_stall),
    .IF_ID_stall      (IF_ID_stall),
    .ID_EX_stall      (ID_EX_stall),
    .ID_EX_bubble     (ID_EX_bubble),
    .EX_MEM_stall     (EX_MEM_stall),
    .EX_MEM_bubble    (EX_MEM_bubble),
    .MEM_WB_bubble    (MEM_WB_bubble),
    .IF_ID_flush      (IF_ID_flush),
    .muldiv_start     (muldiv_start),
    .md_timeout_err   (md_timeout_err),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  task automatic idle_inputs();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_is_muldiv = 1'b0; EX_branch_taken = 1'b0;
    EX_MEM_MemAccess = 1'b0; dmem_ready = 1'b1; muldiv_done = 1'b0;
  endtask

  // Every task starts and ends 1ns after a rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, c_NONE); end
    checks++;
    if ({md_timeout_err, stall_cycles, flush_events} !== 9'd0) begin
      errors++; $display("FAIL reset_regs err=%b stall=%0d flush=%0d exp=0", md_timeout_err, stall_cycles, flush_events);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_hit got=%b exp=%b", ctl, c_LU); end
    next_cycle();
    ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL lu_one_cycle got=%b exp=%b", ctl, c_NONE); end
    checks++;
    if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stall_count got=%0d exp=1", stall_cycles); end
    next_cycle();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; ID_rs2 = 5'd0; ID_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL lu_rd_zero got=%b exp=%b", ctl, c_NONE); end
    next_cycle();
    ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL lu_unused_rs2 got=%b exp=%b", ctl, c_NONE); end
    next_cycle();
    ID_rs2 = 5'd0; ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_rs1_hit got=%b exp=%b", ctl, c_LU); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    EX_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_FLUSH) begin errors++; $display("FAIL br_flush got=%b exp=%b", ctl, c_FLUSH); end
    next_cycle();
    EX_branch_taken = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd7; ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_FLUSH) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", ctl, c_FLUSH); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL br_after got=%b exp=%b", ctl, c_NONE); end
    checks++;
    if (flush_events !== 4'd2 || stall_cycles !== 4'd0) begin
      errors++; $display("FAIL br_counts flush=%0d stall=%0d exp flush=2 stall=0", flush_events, stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_muldiv();
    do_reset();
    ID_EX_is_muldiv = 1'b1;
    muldiv_done = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_MDS) begin errors++; $display("FAIL md_start got=%b exp=%b", ctl, c_MDS); end
    next_cycle();
    muldiv_done = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== c_MDW) begin errors++; $display("FAIL md_wait%0d got=%b exp=%b", i, ctl, c_MDW); end
      next_cycle();
    end
    muldiv_done = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL md_release got=%b exp=%b", ctl, c_NONE); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE || stall_cycles !== 4'd4 || md_timeout_err !== 1'b0) begin
      errors++; $display("FAIL md_after ctl=%b stall=%0d err=%b exp ctl=0 stall=4 err=0", ctl, stall_cycles, md_timeout_err);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    ID_EX_is_muldiv = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_MDS) begin errors++; $display("FAIL to_start got=%b exp=%b", ctl, c_MDS); end
    next_cycle();
    for (int i = 1; i < c_MD_TIMEOUT; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== c_MDW) begin errors++; $display("FAIL to_wait%0d got=%b exp=%b", i, ctl, c_MDW); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE || md_timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_release ctl=%b err=%b exp ctl=0 err=0", ctl, md_timeout_err);
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (md_timeout_err !== 1'b1 || stall_cycles !== 4'd8) begin
      errors++; $display("FAIL to_sticky err=%b stall=%0d exp err=1 stall=8", md_timeout_err, stall_cycles);
    end
    next_cycle();
    do_reset();
    @(negedge clk);
    checks++;
    if (md_timeout_err !== 1'b0) begin errors++; $display("FAIL to_cleared err=%b exp=0", md_timeout_err); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== c_MEMF) begin errors++; $display("FAIL mem_freeze%0d got=%b exp=%b", i, ctl, c_MEMF); end
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL mem_ready got=%b exp=%b", ctl, c_NONE); end
    next_cycle();
    EX_MEM_MemAccess = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== c_FLUSH) begin errors++; $display("FAIL mem_then_flush got=%b exp=%b", ctl, c_FLUSH); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd3 || flush_events !== 4'd1) begin
      errors++; $display("FAIL mem_counts stall=%0d flush=%0d exp stall=3 flush=1", stall_cycles, flush_events);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ID_EX_is_muldiv = 1'b1;
    repeat (3) next_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== c_NONE || stall_cycles !== 4'd0 || md_timeout_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid ctl=%b stall=%0d err=%b exp all 0", ctl, stall_cycles, md_timeout_err);
    end
    next_cycle();
    ID_EX_is_muldiv = 1'b0;
    rst_n = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd9; ID_rs2 = 5'd9; ID_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL rst_mid_run got=%b exp=%b", ctl, c_LU); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
    repeat (20) next_cycle();
    dmem_ready = 1'b1;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d exp=15", stall_cycles); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_timeout();
    test_mem_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the 5-stage RV32 core: generates PC/IF_ID hold, bubble and flush controls for load-use hazards, taken branches, data-memory wait states and the multi-cycle mul/div unit.
- Complements operand forwarding by covering only what forwarding cannot resolve.
- Sits beside the forwarding logic in the datapath top.
- Also keeps saturating performance counters for stall cycles and flush events.

Parameters:
- MD_TIMEOUT, 64, max cycles waited for muldiv_done before abort; must be >= 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  the EX instruction is a load.
- ID_EX_is_muldiv  in  1  the EX instruction is MUL/DIV/REM.
- EX_branch_taken  in  1  the EX branch/jump resolved as a redirect.
- EX_MEM_MemAccess  in  1  the MEM instruction accesses dmem.
- dmem_ready  in  1  dmem completes its access this cycle.
- muldiv_done  in  1  mul/div result is valid this cycle.
- PC_stall, IF_ID_stall  out  1 each  hold the PC / the IF_ID register.
- ID_EX_stall  out  1  hold the ID_EX register.
- ID_EX_bubble  out  1  load a NOP into ID_EX.
- EX_MEM_stall  out  1  hold the EX_MEM register.
- EX_MEM_bubble  out  1  load a NOP into EX_MEM.
- MEM_WB_bubble  out  1  load a NOP into MEM_WB.
- IF_ID_flush  out  1  clear IF_ID to a NOP.
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
- md_timeout_err  out  1  sticky error flag, cleared only by reset.
- stall_cycles  out  CNT_W  count of cycles with PC_stall=1, saturating.
- flush_events  out  CNT_W  count of IF_ID_flush pulses, saturating.

Behaviour:
- States are RUN, MEM_WAIT and MD_WAIT, stored in a registered state plus an md_cnt timeout counter.
- Reset (async, rst_n=0): state=RUN; md_cnt=0; md_timeout_err=0; both counters=0; every control output=0. Reset mid-wait aborts to RUN immediately.
- RUN priority, highest first, evaluated combinationally each cycle:
  1. MEM wait: EX_MEM_MemAccess && !dmem_ready.
     - Assert PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_bubble.
     - Next state MEM_WAIT.
     - Any branch or muldiv in EX is held, not acted on.
  2. Taken branch: EX_branch_taken.
     - Assert IF_ID_flush and ID_EX_bubble.
     - No stall; stay in RUN.
  3. Muldiv: ID_EX_is_muldiv.
     - Assert muldiv_start for one cycle, plus PC_stall, IF_ID_stall, ID_EX_stall and EX_MEM_bubble.
     - md_cnt=1; next state MD_WAIT.
  4. Load-use: ID_EX_MemRead && ID_EX_rd!=0 && ((ID_EX_rd==ID_rs1 && ID_uses_rs1) || (ID_EX_rd==ID_rs2 && ID_uses_rs2)).
     - Assert PC_stall, IF_ID_stall and ID_EX_bubble for exactly this cycle.
     - Stay in RUN. The next cycle no longer matches because a bubble now occupies EX.
- MEM_WAIT:
  - Hold the same outputs as RUN case 1 while dmem_ready=0.
  - When dmem_ready=1, all outputs are 0 and the state returns to RUN. The pipeline advances in that same cycle.
- MD_WAIT:
  - Assert PC_stall, IF_ID_stall, ID_EX_stall and EX_MEM_bubble; muldiv_start=0.
  - md_cnt increments each cycle.
  - On muldiv_done=1: release all stalls that cycle so EX_MEM captures the result; go to RUN.
  - If md_cnt==MD_TIMEOUT without done: set md_timeout_err, release, go to RUN.
  - EX_branch_taken is impossible here (EX holds the muldiv) and is ignored.
- muldiv_done arriving in the start cycle is ignored; completion latency is at least 1 cycle.
- Counters:
  - stall_cycles increments on each cycle with PC_stall=1.
  - flush_events increments on each cycle with IF_ID_flush=1.
  - Both saturate at all-ones and never wrap.
- PC_stall and IF_ID_flush are never both 1 in the same cycle.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, MD_WAIT);
  - REG_ZERO = 5'd0;
  - the default CNT_W.
- One natural sub-module: sat_counter (parameter WIDTH; ports clk, rst_n, inc, count), instantiated twice for the performance counters.

Test Plan:
- Load-use hazard:
  - Stimulus: ID_EX_MemRead=1, ID_EX_rd=5, ID_rs2=5, ID_uses_rs2=1.
  - Response: PC_stall, IF_ID_stall and ID_EX_bubble are 1 for exactly 1 cycle; stall_cycles=1.
  - Repeat with rd=0 or ID_uses_rs2=0: no stall.
- Taken branch:
  - Stimulus: EX_branch_taken=1 for 1 cycle.
  - Response: IF_ID_flush=1 and ID_EX_bubble=1 that cycle, no stall; flush_events=1.
  - With a load-use match present at the same time, the flush wins and no stall occurs.
- Muldiv:
  - Stimulus: ID_EX_is_muldiv=1, muldiv_done 4 cycles later.
  - Response: a single muldiv_start pulse, then stalls held for 4 cycles and released in the done cycle; stall_cycles=4.
- Timeout:
  - Stimulus: muldiv with MD_TIMEOUT=8, done never asserted.
  - Response: release after 8 cycles; md_timeout_err=1 and stays 1 until rst_n pulses low.
- MEM wait with priority:
  - Stimulus: EX_MEM_MemAccess=1, dmem_ready=0 for 3 cycles, with EX_branch_taken=1 during the wait.
  - Response: full freeze for 3 cycles with no flush; after dmem_ready rises, the flush fires the next cycle.
- Reset and saturation:
  - Stimulus: assert rst_n=0 mid MD_WAIT.
  - Response: all outputs 0 immediately, state RUN.
  - Separately, with CNT_W=4, 20 stall cycles leave stall_cycles=15.
